// File: rtl/rgb2hsv_iter.sv
// rgb2hsv_iter: iterative RGB to HSV converter, one pixel in flight at a time.
//
// A pixel is accepted in IDLE. CALC finds max/min/delta and builds the two
// dividends. DIV runs two restoring dividers side by side for DATA_W cycles:
//   hue        = 30*|d| / delta
//   saturation = delta*(2^DATA_W-1) / max
// DONE holds the result until the consumer takes it.
// Latency: the result appears DATA_W+2 cycles after the accepting cycle.
// Throughput: one pixel every DATA_W+3 cycles.
//
// Hue is only exact for DATA_W >= 5. The hue quotient can reach 30, and
// DATA_W quotient bits cannot hold 30 when DATA_W = 4.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_r/in_g/in_b         RGB channels, DATA_W bits each
//   in_user                sideband tag, USER_W bits
//   in_valid/in_ready      input handshake; in_ready is high only in IDLE
//   out_h                  hue in half-degrees, 0..179
//   out_s/out_v            saturation and value, DATA_W bits each
//   out_user               tag belonging to the pixel on out_*
//   out_valid/out_ready    output handshake; out_valid is high only in DONE
module rgb2hsv_iter #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic [USER_W-1:0] in_user,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_h,
    output logic [DATA_W-1:0] out_s,
    output logic [DATA_W-1:0] out_v,
    output logic [USER_W-1:0] out_user,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [1:0] SEL_R = 2'd0;
    localparam logic [1:0] SEL_G = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] pix_r, pix_g, pix_b;
    logic [USER_W-1:0] pix_user;
    logic [1:0]        max_sel;
    logic              hue_neg;
    logic [DATA_W-1:0] div_h, div_s;
    logic [DATA_W-1:0] rem_h, quo_h, rem_s, quo_s;
    logic [CNT_W-1:0]  iter_cnt;
    logic              last_iter;

    logic [DATA_W-1:0]   calc_max, calc_min, calc_delta, calc_absd;
    logic [1:0]          calc_sel;
    logic                calc_neg;
    logic [2*DATA_W-1:0] calc_nh, calc_ns;

    logic [DATA_W:0]   trial_h, trial_s;
    logic              take_h, take_s;
    logic [DATA_W-1:0] step_rem_h, step_quo_h, step_rem_s, step_quo_s;
    logic [7:0]        q8, hue8;

    assign last_iter = (iter_cnt == LAST_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: state_next = DIV;
            DIV:  if (last_iter) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Find the max channel (ties go to R, then G) and the hue difference d.
    // d is kept as a magnitude plus a sign so the divider can stay unsigned.
    always_comb begin
        calc_sel  = SEL_R;
        calc_max  = pix_r;
        calc_neg  = 1'b0;
        calc_absd = '0;
        if (pix_r >= pix_g && pix_r >= pix_b) begin
            calc_sel  = SEL_R;
            calc_max  = pix_r;
            calc_neg  = pix_g < pix_b;
            calc_absd = calc_neg ? pix_b - pix_g : pix_g - pix_b;
        end else if (pix_g >= pix_b) begin
            calc_sel  = SEL_G;
            calc_max  = pix_g;
            calc_neg  = pix_b < pix_r;
            calc_absd = calc_neg ? pix_r - pix_b : pix_b - pix_r;
        end else begin
            calc_sel  = SEL_B;
            calc_max  = pix_b;
            calc_neg  = pix_r < pix_g;
            calc_absd = calc_neg ? pix_g - pix_r : pix_r - pix_g;
        end
        calc_min = pix_r;
        if (pix_g < calc_min) calc_min = pix_g;
        if (pix_b < calc_min) calc_min = pix_b;
        calc_delta = calc_max - calc_min;
        calc_nh    = (2*DATA_W)'(calc_absd) * (2*DATA_W)'(30);
        // delta*(2^W-1) is computed as (delta << W) - delta.
        calc_ns    = {calc_delta, {DATA_W{1'b0}}} - {{DATA_W{1'b0}}, calc_delta};
    end

    // One restoring-division step for each divider. The dividend's low half
    // shifts out MSB first through quo_*, and quotient bits shift in behind it.
    // Each dividend's upper half is below its divisor, so DATA_W steps are
    // enough for the quotient.
    always_comb begin
        trial_h    = {rem_h, quo_h[DATA_W-1]};
        take_h     = trial_h >= {1'b0, div_h};
        step_rem_h = take_h ? DATA_W'(trial_h - {1'b0, div_h}) : trial_h[DATA_W-1:0];
        step_quo_h = {quo_h[DATA_W-2:0], take_h};
        trial_s    = {rem_s, quo_s[DATA_W-1]};
        take_s     = trial_s >= {1'b0, div_s};
        step_rem_s = take_s ? DATA_W'(trial_s - {1'b0, div_s}) : trial_s[DATA_W-1:0];
        step_quo_s = {quo_s[DATA_W-2:0], take_s};
    end

    // Map the hue quotient (at most 30) onto the 0..179 circle.
    // For R max, a negative d wraps around to 180-q.
    always_comb begin
        q8 = 8'(step_quo_h);
        case (max_sel)
            SEL_G:   hue8 = hue_neg ? 8'd60 - q8 : 8'd60 + q8;
            SEL_B:   hue8 = hue_neg ? 8'd120 - q8 : 8'd120 + q8;
            default: hue8 = (hue_neg && q8 != 8'd0) ? 8'd180 - q8 : q8;
        endcase
    end

    // Datapath: capture, set up the dividers, iterate, and register results.
    // The outputs load on the last DIV step, so they hold steady through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_r    <= '0;
            pix_g    <= '0;
            pix_b    <= '0;
            pix_user <= '0;
            max_sel  <= SEL_R;
            hue_neg  <= 1'b0;
            div_h    <= '0;
            div_s    <= '0;
            rem_h    <= '0;
            quo_h    <= '0;
            rem_s    <= '0;
            quo_s    <= '0;
            iter_cnt <= '0;
            out_h    <= '0;
            out_s    <= '0;
            out_v    <= '0;
            out_user <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pix_r    <= in_r;
                        pix_g    <= in_g;
                        pix_b    <= in_b;
                        pix_user <= in_user;
                    end
                end
                CALC: begin
                    max_sel  <= calc_sel;
                    hue_neg  <= calc_neg;
                    div_h    <= calc_delta;
                    div_s    <= calc_max;
                    rem_h    <= calc_nh[2*DATA_W-1:DATA_W];
                    quo_h    <= calc_nh[DATA_W-1:0];
                    rem_s    <= calc_ns[2*DATA_W-1:DATA_W];
                    quo_s    <= calc_ns[DATA_W-1:0];
                    iter_cnt <= '0;
                end
                DIV: begin
                    rem_h    <= step_rem_h;
                    quo_h    <= step_quo_h;
                    rem_s    <= step_rem_s;
                    quo_s    <= step_quo_s;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (last_iter) begin
                        // Grey and black pixels divide by zero. They still take
                        // the full divider time; only the result is forced.
                        out_h    <= (div_h == '0) ? 8'd0 : hue8;
                        out_s    <= (div_h == '0) ? '0 : step_quo_s;
                        out_v    <= div_s;
                        out_user <= pix_user;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb2hsv_iter.sv
// Testbench for rgb2hsv_iter (DATA_W=8, USER_W=1).
// Directed pixels have known answers. Random streaming traffic is compared
// in order against an arithmetic HSV reference model.
module tb_rgb2hsv_iter;
    localparam int DATA_W   = 8;
    localparam int USER_W   = 1;
    localparam int N_RANDOM = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic [USER_W-1:0] in_user = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        out_h;
    logic [DATA_W-1:0] out_s, out_v;
    logic [USER_W-1:0] out_user;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int recv   = 0;

    logic [24:0] exp_q[$];
    int          acc_q[$];

    rgb2hsv_iter #(.DATA_W(DATA_W), .USER_W(USER_W)) dut (
        .clk(clk), .rst(rst),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_user(out_user),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // HSV from the definition: hue = base +/- floor(30|d|/delta), wrapped into
    // 0..179; sat = floor(delta*255/max); grey pixels get hue = sat = 0.
    function automatic logic [24:0] model(input int r, input int g, input int b, input int u);
        int mx, mn, dl, d, base, q, h, s;
        mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
        dl = mx - mn;
        h = 0; s = 0;
        if (dl != 0) begin
            s = (dl * 255) / mx;
            if (r == mx)      begin d = g - b; base = 0;   end
            else if (g == mx) begin d = b - r; base = 60;  end
            else              begin d = r - g; base = 120; end
            q = (30 * ((d < 0) ? -d : d)) / dl;
            h = (d >= 0) ? base + q : base - q;
            if (h < 0) h += 180;
        end
        return {8'(h), 8'(s), 8'(mx), 1'(u)};
    endfunction

    // Scoreboard monitor. It samples after the driver has settled each cycle
    // and tracks transfers that complete on the next edge.
    logic        prev_ov = 1'b0, prev_ordy = 1'b0;
    logic [24:0] prev_out = '0;
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (prev_ov && !prev_ordy) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", {out_h, out_s, out_v, out_user}, prev_out);
            end
            if (out_valid) checkOutput("in_ready_low_in_done", in_ready, 0);
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) checkOutput("spurious_valid", out_valid, 0);
                else checkOutput("latency", cyc - acc_q[0], DATA_W + 2);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) checkOutput("spurious_transfer", out_valid, 0);
                else begin
                    checkOutput("pixel", {out_h, out_s, out_v, out_user}, exp_q.pop_front());
                    void'(acc_q.pop_front());
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_r, in_g, in_b, in_user));
                acc_q.push_back(cyc);
            end
            prev_ov   = out_valid;
            prev_ordy = out_ready;
            prev_out  = {out_h, out_s, out_v, out_user};
        end
    end

    // Send one pixel with out_ready held high and check it against known values.
    task automatic applyStimulus(input int r, input int g, input int b, input int u,
                                 input int eh, input int es, input int ev);
        int n, acc;
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b); in_user = 1'(u);
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("valid_seen", out_valid, 1);
        checkOutput("latency_dir", cyc - acc, DATA_W + 2);
        checkOutput("hue", out_h, eh);
        checkOutput("sat", out_s, es);
        checkOutput("val", out_v, ev);
        checkOutput("user", out_user, u);
        @(posedge clk); #1;
        checkOutput("ready_after_done", in_ready, 1);
        checkOutput("valid_dropped", out_valid, 0);
    endtask

    initial begin
        int n, acc, sent, guard;
        logic fire;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_outputs", {out_h, out_s, out_v, out_user}, 0);

        // Primaries, wrap, tie, general, grey, black.
        applyStimulus(255, 0, 0, 1, 0, 255, 255);
        applyStimulus(0, 255, 0, 0, 60, 255, 255);
        applyStimulus(0, 0, 255, 1, 120, 255, 255);
        applyStimulus(255, 0, 255, 0, 150, 255, 255);
        applyStimulus(255, 255, 0, 1, 30, 255, 255);
        applyStimulus(200, 100, 50, 0, 10, 191, 200);
        applyStimulus(128, 128, 128, 1, 0, 0, 128);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Backpressure: hold DONE for 5 cycles.
        out_ready = 1'b0;
        in_r = 8'd200; in_g = 8'd100; in_b = 8'd50; in_user = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_hsv", {out_h, out_s, out_v}, {8'd10, 8'd191, 8'd200});
            checkOutput("bp_user", out_user, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_ready", in_ready, 1);

        // Reset on the 4th DIV cycle aborts the pixel.
        in_r = 8'd255; in_g = 8'd0; in_b = 8'd0; in_user = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_outputs", {out_h, out_s, out_v, out_user}, 0);
        for (int i = 0; i < 14; i++) begin
            checkOutput("abort_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        applyStimulus(0, 255, 0, 0, 60, 255, 255);

        // Random streaming with random in_valid/out_ready.
        recv = 0;
        sent = 0;
        guard = 0;
        fire = 1'b0;
        while (recv < N_RANDOM && guard < 80000) begin
            @(posedge clk); #1;
            guard++;
            if (fire) begin sent++; in_valid = 1'b0; end
            if (!in_valid && sent < N_RANDOM && $urandom_range(0, 3) != 0) begin
                in_r = 8'($urandom_range(0, 255));
                in_g = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) in_g = in_r;
                if ($urandom_range(0, 7) == 0) in_b = in_r;
                in_user = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fire = in_valid && in_ready;
        end
        checkOutput("stream_count", recv, N_RANDOM);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1 checkOutput("stream_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
